fosfor_present_host: RTL and testbench
======================================

// Module: fosfor_present_host
// PURPOSE
//  Bus initiator for the PRESENT nibble bus (2-bit address, 4-bit write data, 8-bit read data).
//  Accepts a 64-bit plaintext and an 80-bit key, uploads both through the bus, starts the engine,
//  polls status and reads back the 64-bit ciphertext. Lives in the FPGA/test harness next to the
//  PRESENT top, on the same clock.
// PARAMETERS
//  START_HOLDOFF  2     poll cycles after the start command whose status sample is ignored
//  TIMEOUT_CYCLES 1024  max poll cycles, including holdoff, before a run aborts
// PORTS
//  Clk_ik         in   1   clock; all bus outputs change on the posedge
//  Reset_irn      in   1   asynchronous, active-low reset
//  Start_i        in   1   request a run; sampled only in IDLE
//  PlainText_ib   in   64  plaintext; captured when the request is accepted
//  Key_ib         in   80  key; captured when the request is accepted
//  Busy_o         out  1   high from the accepting edge until the Done/Error edge
//  Done_o         out  1   1-cycle pulse; CipherText_ob valid from this cycle on
//  Error_o        out  1   sticky poll timeout; cleared when the next request is accepted
//  CipherText_ob  out  64  last good ciphertext; held until the next Done
//  BusAddr_ob     out  2   to PRESENT Addr_ib. 00 idle/status, 01 cmd, 10 data lo / read, 11 data hi
//  BusData_ob     out  4   to PRESENT Data_ib
//  BusData_ib     in   8   from PRESENT Data_ob. Bit 0 = Ready when addr=00; byte when addr=1x
// BEHAVIOUR
//  - Reset values: all outputs 0; BusAddr_ob=00 (no write). Reset mid-run aborts at once:
//    no Done, no Error.
//  - Accept: IDLE and Start_i=1 at an edge. Capture PT/Key, set Busy_o, clear Error_o.
//    The first bus cycle follows that edge.
//  - Bus cycle = one clock with registered BusAddr_ob/BusData_ob. Every command cycle is
//    followed by one GAP cycle (addr 00, data 0).
//  - LOAD_ADDR(A), 4 cycles: (10,A[3:0]) (11,A[7:4]) (01,4'b0001) GAP.
//  - WRITE_BYTE(A,B), 8 cycles: LOAD_ADDR(A), then (10,B[3:0]) (11,B[7:4]) (01,4'b0100) GAP.
//  - Upload order: key regs 0x10..0x19 (byte n = Key[8n+7:8n]), then PT regs 0x00..0x07.
//    Total 144 cycles.
//  - START, 2 cycles: (01,4'b1000), GAP.
//  - POLL: drive (00,0) and sample BusData_ib[0] at each edge.
//    - The first START_HOLDOFF samples are ignored.
//    - First later sample of 1 ends polling.
//    - If TIMEOUT_CYCLES poll cycles pass without that, go to ERR: Error_o=1, Busy_o=0,
//      bus idle, CipherText_ob unchanged.
//  - READ, 5 cycles per byte n=0..7: LOAD_ADDR(n), then (10,0).
//    BusData_ib is sampled at the edge ending the (10,0) cycle and stored into CT[8n+7:8n].
//    The addr-10 write to the PRESENT input-data low nibble is harmless.
//  - DONE: the edge after the byte-7 sample updates CipherText_ob, pulses Done_o, clears
//    Busy_o and returns to IDLE. Start_i in that cycle is taken on the next edge.
//  - Start_i while Busy_o=1 is ignored, not queued.
//  - FSM: IDLE -> UPLOAD -> START -> POLL -> READ -> DONE -> IDLE; POLL -> ERR -> IDLE.
//    UPLOAD, START and READ are sequenced by byte and phase counters.
//  - Latency, accept edge to Done edge: 144 + 2 + P + 40 + 1. P = poll cycles up to and
//    including the Ready sample.
// CONFIGURATION
//  FOSFOR_KEY_CACHE_EN defined:
//    - The block holds the last uploaded key and a KeyValid flag. KeyValid is cleared by
//      reset and by a timeout, and set when a run reaches DONE.
//    - If KeyValid is set and the captured key equals the held key, key upload is skipped:
//      upload is 64 cycles, plaintext only.
//  FOSFOR_KEY_CACHE_EN undefined: the key is always uploaded (144 cycles); no key storage.
// TESTING (bench pairs this block with the PRESENT top, shared Clk_ik)
//  1. Reset_irn low mid-upload -> all outputs 0 at once; new Start completes with a correct CT.
//  2. PT=0, K=0 -> CipherText_ob=64'h5579C1387B228445; one Done_o pulse;
//     Busy_o high for 187+P cycles.
//  3. PT=0, K=80'hFF..FF -> 64'hE72C46C0F5945049;
//     PT=64'hFF..FF, K=0 -> 64'hA112FFC72F68417B.
//  4. Bus trace after accept, K byte0=0xA5 -> (10,0)(11,1)(01,1)(00,0)(10,5)(11,A)(01,4)(00,0).
//  5. Ready forced 0 -> Error_o=1 after 1024 poll cycles; no Done_o; CipherText_ob unchanged.
//  6. CACHE_EN: two runs with the same key -> second run 80 cycles shorter, same correct CT.
//     Then change the key -> full 144-cycle upload.

Source files
------------

// File: rtl/fosfor_present_host.sv
// fosfor_present_host: PRESENT nibble-bus initiator that uploads key/plaintext, starts, polls and reads back the ciphertext.
// Define FOSFOR_KEY_CACHE_EN to skip re-uploading a key equal to the one used by the last completed run.
module fosfor_present_host #(
    parameter int START_HOLDOFF  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        Clk_ik,
    input  logic        Reset_irn,
    input  logic        Start_i,
    input  logic [63:0] PlainText_ib,
    input  logic [79:0] Key_ib,
    output logic        Busy_o,
    output logic        Done_o,
    output logic        Error_o,
    output logic [63:0] CipherText_ob,
    output logic [1:0]  BusAddr_ob,
    output logic [3:0]  BusData_ob,
    input  logic [7:0]  BusData_ib
);
    localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {S_IDLE, S_UPLOAD, S_START, S_POLL, S_READ, S_DONE, S_ERR} state_t;
    state_t        r_state, w_state;
    logic [4:0]    r_byte, w_byte, w_off;
    logic [2:0]    r_ph, w_ph;
    logic [PW-1:0] r_poll, w_poll, w_poll_n;
    logic [79:0]   r_key;
    logic [63:0]   r_pt, r_ct;
    logic [7:0]    w_a8, w_d8, w_sel;
    logic [1:0]    w_addr;
    logic [3:0]    w_data;
    logic          w_accept, w_skip;

`ifdef FOSFOR_KEY_CACHE_EN
    logic [79:0] r_key_held;
    logic        r_key_valid;
    assign w_skip = r_key_valid && (Key_ib == r_key_held);
    always_ff @(posedge Clk_ik or negedge Reset_irn) begin
        if (!Reset_irn) begin
            r_key_held  <= '0;
            r_key_valid <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_key_held  <= r_key;
            r_key_valid <= 1'b1;
        end else if (r_state == S_ERR) begin
            r_key_valid <= 1'b0;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && Start_i;
    assign w_poll_n = r_poll + PW'(1);

    // Bus values are derived from the next state/counters so they leave the flops with the state.
    always_comb begin
        w_state = r_state;
        w_byte  = r_byte;
        w_ph    = r_ph + 3'd1;
        w_poll  = r_poll;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_state = S_UPLOAD;
                w_byte  = w_skip ? 5'd10 : 5'd0;
                w_ph    = 3'd0;
            end
            S_UPLOAD: if (r_ph == 3'd7) begin
                w_state = (r_byte == 5'd17) ? S_START : S_UPLOAD;
                w_byte  = r_byte + 5'd1;
            end
            S_START: if (r_ph[0]) begin
                w_state = S_POLL;
                w_poll  = '0;
            end
            S_POLL: begin
                w_poll = w_poll_n;
                if (w_poll_n > PW'(START_HOLDOFF) && BusData_ib[0]) begin
                    w_state = S_READ;
                    w_byte  = 5'd0;
                    w_ph    = 3'd0;
                end else if (w_poll_n == PW'(TIMEOUT_CYCLES)) begin
                    w_state = S_ERR;
                end
            end
            S_READ: if (r_ph == 3'd4) begin
                w_ph    = 3'd0;
                w_byte  = r_byte + 5'd1;
                w_state = (r_byte == 5'd7) ? S_DONE : S_READ;
            end
            default: w_state = S_IDLE;
        endcase
        w_off  = w_byte - 5'd10;
        w_a8   = (w_state == S_READ) ? {5'd0, w_byte[2:0]} :
                 (w_byte < 5'd10) ? {4'h1, w_byte[3:0]} : {4'h0, w_off[3:0]};
        w_d8   = (w_state == S_READ) ? 8'h00 :
                 (w_byte < 5'd10) ? 8'(r_key >> {w_byte, 3'b000}) : 8'(r_pt >> {w_off, 3'b000});
        w_sel  = w_ph[2] ? w_d8 : w_a8;
        w_addr = 2'b00;
        w_data = 4'h0;
        if (w_state == S_UPLOAD || w_state == S_READ) begin
            w_addr = {~w_ph[1], w_ph[0] ^ w_ph[1]};
            w_data = w_ph[1] ? (w_ph[0] ? 4'h0 : (w_ph[2] ? 4'h4 : 4'h1)) :
                     (w_ph[0] ? w_sel[7:4] : w_sel[3:0]);
        end else if (w_state == S_START && !w_ph[0]) begin
            w_addr = 2'b01;
            w_data = 4'h8;
        end
    end

    always_ff @(posedge Clk_ik or negedge Reset_irn) begin
        if (!Reset_irn) begin
            r_state       <= S_IDLE;
            r_byte        <= '0;
            r_ph          <= '0;
            r_poll        <= '0;
            r_key         <= '0;
            r_pt          <= '0;
            r_ct          <= '0;
            Busy_o        <= 1'b0;
            Done_o        <= 1'b0;
            Error_o       <= 1'b0;
            CipherText_ob <= '0;
            BusAddr_ob    <= '0;
            BusData_ob    <= '0;
        end else begin
            r_state    <= w_state;
            r_byte     <= w_byte;
            r_ph       <= w_ph;
            r_poll     <= w_poll;
            BusAddr_ob <= w_addr;
            BusData_ob <= w_data;
            Done_o     <= (r_state == S_DONE);
            if (w_accept) begin
                r_key   <= Key_ib;
                r_pt    <= PlainText_ib;
                Busy_o  <= 1'b1;
                Error_o <= 1'b0;
            end
            if (r_state == S_READ && r_ph == 3'd4)
                r_ct <= {BusData_ib, r_ct[63:8]};
            if (r_state == S_DONE) begin
                CipherText_ob <= r_ct;
                Busy_o        <= 1'b0;
            end
            if (w_state == S_ERR) begin
                Error_o <= 1'b1;
                Busy_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fosfor_present_host.sv
// tb_fosfor_present_host: drives fosfor_present_host against a behavioural PRESENT bus target and cipher model.
module tb_fosfor_present_host;
    localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [63:0] pt = '0;
    logic [79:0] key = '0;
    logic        busy, done, err;
    logic [63:0] ct;
    logic [1:0]  baddr;
    logic [3:0]  bdata;
    logic [7:0]  bin;
    int          tests = 0, fails = 0;

    logic [3:0]  s_dlo = '0, s_dhi = '0;
    logic [7:0]  s_areg = '0;
    logic [79:0] s_key = '0;
    logic [63:0] s_pt = '0, s_ct = 64'h0123456789ABCDEF;
    logic        s_ready = 1'b1;
    logic [1:0]  s_lag = '0;
    int          s_cnt = 0, delay = 0;
    bit          force0 = 1'b0;

    bit          m_valid = 1'b0;
    logic [79:0] m_key = '0;
    logic [63:0] m_ct = '0;

    always #5 clk = ~clk;

    fosfor_present_host dut (
        .Clk_ik(clk), .Reset_irn(rst_n), .Start_i(start), .PlainText_ib(pt), .Key_ib(key),
        .Busy_o(busy), .Done_o(done), .Error_o(err), .CipherText_ob(ct),
        .BusAddr_ob(baddr), .BusData_ob(bdata), .BusData_ib(bin)
    );

    function automatic logic [63:0] present(input logic [63:0] p, input logic [79:0] k);
        logic [63:0] s, t;
        logic [79:0] kk;
        s  = p;
        kk = k;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SBOX[{s[4*n +: 4], 2'b00} +: 4];
            for (int b = 0; b < 64; b++) s[(b == 63) ? 63 : (b * 16) % 63] = t[b];
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = SBOX[{kk[79:76], 2'b00} +: 4];
            kk[19:15] = kk[19:15] ^ 5'(r);
        end
        return s ^ kk[79:16];
    endfunction

    // Bus target: stale Ready lingers two edges after START, then Ready returns after 'delay' cycles.
    assign bin = (baddr == 2'b00) ? {7'd0, s_ready} : s_ct[{s_areg[2:0], 3'b000} +: 8];
    always @(posedge clk) begin
        if (baddr == 2'b10) s_dlo <= bdata;
        if (baddr == 2'b11) s_dhi <= bdata;
        if (baddr == 2'b01 && bdata[0]) s_areg <= {s_dhi, s_dlo};
        if (baddr == 2'b01 && bdata[2] && s_areg[7:4] == 4'h1 && s_areg[3:0] < 4'd10)
            s_key[{s_areg[3:0], 3'b000} +: 8] <= {s_dhi, s_dlo};
        if (baddr == 2'b01 && bdata[2] && s_areg[7:4] == 4'h0 && s_areg[3:0] < 4'd8)
            s_pt[{s_areg[2:0], 3'b000} +: 8] <= {s_dhi, s_dlo};
        if (baddr == 2'b01 && bdata[3]) begin
            s_lag <= 2'd2;
            s_cnt <= delay;
        end else if (s_lag != 2'd0) begin
            s_lag <= s_lag - 2'd1;
            if (s_lag == 2'd1) s_ready <= 1'b0;
        end else if (!s_ready && !force0) begin
            if (s_cnt == 0) begin
                s_ready <= 1'b1;
                s_ct    <= present(s_pt, s_key);
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [63:0] p, input logic [79:0] k, input int d, input bit f0, input string tag);
        int         n, dones, u;
        bit         skip;
        logic [7:0] a8, d8;
        logic [5:0] tr [8];
        logic [5:0] ex [8];
        skip = 1'b0;
`ifdef FOSFOR_KEY_CACHE_EN
        skip = m_valid && (k == m_key);
`endif
        u  = skip ? 64 : 144;
        a8 = skip ? 8'h00 : 8'h10;
        d8 = skip ? p[7:0] : k[7:0];
        ex = '{{2'b10, a8[3:0]}, {2'b11, a8[7:4]}, 6'b01_0001, 6'b00_0000,
               {2'b10, d8[3:0]}, {2'b11, d8[7:4]}, 6'b01_0100, 6'b00_0000};
        for (int i = 0; i < 8; i++) tr[i] = 6'h3F;
        n = 0;
        dones = 0;
        delay = d;
        force0 = f0;
        @(negedge clk);
        pt = p;
        key = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && n < 3000) begin
            if (n < 8) tr[n] = {baddr, bdata};
            if (n == 100) start = 1'b1;
            if (n == 102) start = 1'b0;
            if (done === 1'b1) dones++;
            n++;
            @(negedge clk);
        end
        check({tag, ".cycles"}, 64'(n), 64'(f0 ? u + 2 + 1024 : u + 46 + d));
        for (int i = 0; i < 8; i++) check($sformatf("%s.bus%0d", tag, i), 64'(tr[i]), 64'(ex[i]));
        check({tag, ".early_done"}, 64'(dones), 64'(0));
        check({tag, ".done"}, 64'(done), 64'(!f0));
        check({tag, ".error"}, 64'(err), 64'(f0));
        check({tag, ".ct"}, ct, f0 ? m_ct : present(p, k));
        @(negedge clk);
        check({tag, ".after"}, {61'd0, err, done, busy}, {61'd0, f0, 2'b00});
        if (f0) m_valid = 1'b0;
        else begin
            m_valid = 1'b1;
            m_key = k;
            m_ct = present(p, k);
        end
    endtask

    function automatic logic [79:0] rnd80();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    initial begin
        logic [79:0] k;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.ctl", {61'd0, busy, done, err}, 64'd0);
        check("rst.ct", ct, 64'd0);
        check("rst.bus", {58'd0, baddr, bdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        pt = {$urandom(), $urandom()};
        key = rnd80();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("mid.busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid.ctl", {61'd0, busy, done, err}, 64'd0);
        check("mid.ct", ct, 64'd0);
        check("mid.bus", {58'd0, baddr, bdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0;
        m_ct = '0;
        run(64'h0, 80'h0, 0, 1'b0, "zero");
        check("vec0", ct, 64'h5579C1387B228445);
        run(64'h0, {80{1'b1}}, 5, 1'b0, "kones");
        check("vec1", ct, 64'hE72C46C0F5945049);
        run({64{1'b1}}, 80'h0, int'($urandom_range(0, 20)), 1'b0, "pones");
        check("vec2", ct, 64'hA112FFC72F68417B);
        k = {rnd80()};
        k[7:0] = 8'hA5;
        run({$urandom(), $urandom()}, k, int'($urandom_range(0, 20)), 1'b0, "a5");
        run({$urandom(), $urandom()}, rnd80(), 0, 1'b1, "tmo");
        k = rnd80();
        run({$urandom(), $urandom()}, k, int'($urandom_range(0, 20)), 1'b0, "same1");
        run({$urandom(), $urandom()}, k, int'($urandom_range(0, 20)), 1'b0, "same2");
        run({$urandom(), $urandom()}, rnd80(), int'($urandom_range(0, 20)), 1'b0, "newkey");
        for (int i = 0; i < 3; i++)
            run({$urandom(), $urandom()}, rnd80(), int'($urandom_range(0, 20)), 1'b0, $sformatf("rand%0d", i));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
